even_parity_generator: RTL and testbench

Even-parity generator for a parameterizable data word. It produces a combinational parity bit and a registered, valid-qualified codeword of data plus parity. It sits at the transmit edge of a link, ahead of serializers and storage. An optional receive-side checker verifies incoming codewords and counts errors.

---
 rtl/epg_pkg.sv | 12 +
 rtl/epg_parity_tree.sv | 13 +
 rtl/even_parity_generator.sv | 107 ++++++++++
 tb/tb_even_parity_generator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/epg_pkg.sv
// Shared defaults and the even-parity helper for the even_parity_generator slice.
package epg_pkg;

    localparam int EPG_DEFAULT_WIDTH = 4;
    localparam int EPG_DEFAULT_CNT_W = 16;

    // Callers zero-extend narrower words; padding zeros do not change parity.
    function automatic logic epg_even_parity(input logic [63:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/epg_parity_tree.sv
// XOR reduction of a WIDTH-bit word to a single even-parity bit.
module epg_parity_tree
    import epg_pkg::*;
#(
    parameter int WIDTH = EPG_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    assign parity = epg_even_parity(64'(data));

endmodule

// File: rtl/even_parity_generator.sv
// Transmit-side even-parity generator with registered codeword output.
// Define EPG_CHECK_EN to add the receive-side checker with saturating error count.
module even_parity_generator
    import epg_pkg::*;
#(
    parameter int WIDTH = EPG_DEFAULT_WIDTH
`ifdef EPG_CHECK_EN
    ,
    parameter int CNT_W = EPG_DEFAULT_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             parity,
    output logic [WIDTH-1:0] data_out,
    output logic             parity_out,
    output logic             valid_out
`ifdef EPG_CHECK_EN
    ,
    input  logic [WIDTH-1:0] chk_data,
    input  logic             chk_parity,
    input  logic             chk_valid,
    input  logic             cnt_clr,
    output logic             chk_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky
`endif
);

    logic             gen_parity;
    logic [WIDTH-1:0] data_p1;
    logic             parity_p1;
    logic             vld_p1;

    epg_parity_tree #(.WIDTH(WIDTH)) u_gen_tree (
        .data   (data_in),
        .parity (gen_parity)
    );

    assign parity = gen_parity;

    // Stage p1: registered codeword; data and parity hold while valid_in is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1   <= '0;
            parity_p1 <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= valid_in;
            if (valid_in) begin
                data_p1   <= data_in;
                parity_p1 <= gen_parity;
            end
        end
    end

    assign data_out   = data_p1;
    assign parity_out = parity_p1;
    assign valid_out  = vld_p1;

`ifdef EPG_CHECK_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             chk_calc;
    logic             chk_mismatch;
    logic [CNT_W-1:0] cnt_base;
    logic             chk_err_p1;
    logic [CNT_W-1:0] err_cnt_p1;
    logic             err_sticky_p1;

    epg_parity_tree #(.WIDTH(WIDTH)) u_chk_tree (
        .data   (chk_data),
        .parity (chk_calc)
    );

    assign chk_mismatch = chk_valid & (chk_calc ^ chk_parity);
    // Clear takes effect before the increment, so clear+error leaves a count of one.
    assign cnt_base     = cnt_clr ? '0 : err_cnt_p1;

    // Stage p1: error pulse, saturating count and sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_p1    <= 1'b0;
            err_cnt_p1    <= '0;
            err_sticky_p1 <= 1'b0;
        end else begin
            chk_err_p1 <= chk_mismatch;
            if (chk_mismatch) begin
                err_cnt_p1    <= sat_inc(cnt_base);
                err_sticky_p1 <= 1'b1;
            end else begin
                err_cnt_p1    <= cnt_base;
                err_sticky_p1 <= err_sticky_p1 & ~cnt_clr;
            end
        end
    end

    assign chk_err    = chk_err_p1;
    assign err_cnt    = err_cnt_p1;
    assign err_sticky = err_sticky_p1;
`endif

endmodule

// File: tb/tb_even_parity_generator.sv
// Directed self-checking bench for even_parity_generator (WIDTH = 4, checker CNT_W = 2).
module tb_even_parity_generator;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             parity;
    logic [WIDTH-1:0] data_out;
    logic             parity_out;
    logic             valid_out;

`ifdef EPG_CHECK_EN
    localparam int CNT_W = 2;
    logic [WIDTH-1:0] chk_data;
    logic             chk_parity;
    logic             chk_valid;
    logic             cnt_clr;
    logic             chk_err;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    even_parity_generator #(
        .WIDTH(WIDTH)
`ifdef EPG_CHECK_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .parity     (parity),
        .data_out   (data_out),
        .parity_out (parity_out),
        .valid_out  (valid_out)
`ifdef EPG_CHECK_EN
        ,
        .chk_data   (chk_data),
        .chk_parity (chk_parity),
        .chk_valid  (chk_valid),
        .cnt_clr    (cnt_clr),
        .chk_err    (chk_err),
        .err_cnt    (err_cnt),
        .err_sticky (err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; drive one valid word, check comb parity, then the registered copy.
    task automatic send(input logic [WIDTH-1:0] d, input logic exp_p, input string tag);
        data_in  = d;
        valid_in = 1'b1;
        #1;
        check({tag, "_parity"}, 64'(parity), 64'(exp_p));
        @(negedge clk);
        check({tag, "_data_out"}, 64'(data_out), 64'(d));
        check({tag, "_parity_out"}, 64'(parity_out), 64'(exp_p));
        check({tag, "_valid_out"}, 64'(valid_out), 64'(1'b1));
    endtask

    logic [15:0] ptab;
    logic [3:0]  sweep_d [4];
    logic        sweep_p [4];

    initial begin
        ptab = 16'h6996;  // parity of index 0..15, bit i
        sweep_d[0] = 4'b0000; sweep_p[0] = 1'b0;
        sweep_d[1] = 4'b1011; sweep_p[1] = 1'b1;
        sweep_d[2] = 4'b1100; sweep_p[2] = 1'b0;
        sweep_d[3] = 4'b1111; sweep_p[3] = 1'b0;

        rst_n    = 1'b0;
        data_in  = 4'b0000;
        valid_in = 1'b0;
`ifdef EPG_CHECK_EN
        chk_data   = '0;
        chk_parity = 1'b0;
        chk_valid  = 1'b0;
        cnt_clr    = 1'b0;
`endif
        #2;
        check("rst_data_out", 64'(data_out), 64'(0));
        check("rst_parity_out", 64'(parity_out), 64'(0));
        check("rst_valid_out", 64'(valid_out), 64'(0));
`ifdef EPG_CHECK_EN
        check("rst_chk_err", 64'(chk_err), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_err_sticky", 64'(err_sticky), 64'(0));
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) send(sweep_d[i], sweep_p[i], "sweep");

        for (int i = 0; i < 16; i++) begin
            logic [WIDTH-1:0] v;
            v = 4'(i);
            send(v, ptab[i], "exh");
        end

        send(4'b1011, 1'b1, "pre_hold");
        valid_in = 1'b0;
        data_in  = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_data_out", 64'(data_out), 64'(4'b1011));
            check("hold_parity_out", 64'(parity_out), 64'(1'b1));
            check("hold_valid_out", 64'(valid_out), 64'(1'b0));
        end

`ifdef EPG_CHECK_EN
        chk_data = 4'b1011; chk_parity = 1'b1; chk_valid = 1'b1;
        @(negedge clk);
        check("chk_good_err", 64'(chk_err), 64'(0));
        check("chk_good_cnt", 64'(err_cnt), 64'(0));
        chk_parity = 1'b0;
        @(negedge clk);
        check("chk_bad_err", 64'(chk_err), 64'(1));
        check("chk_bad_cnt", 64'(err_cnt), 64'(1));
        check("chk_bad_sticky", 64'(err_sticky), 64'(1));
        chk_valid = 1'b0; cnt_clr = 1'b1;
        @(negedge clk);
        check("clr_cnt", 64'(err_cnt), 64'(0));
        check("clr_sticky", 64'(err_sticky), 64'(0));
        check("clr_err_idle", 64'(chk_err), 64'(0));
        cnt_clr = 1'b0; chk_valid = 1'b1;
        @(negedge clk);
        check("pre_coinc_cnt", 64'(err_cnt), 64'(1));
        cnt_clr = 1'b1;
        @(negedge clk);
        check("coinc_cnt", 64'(err_cnt), 64'(1));
        check("coinc_sticky", 64'(err_sticky), 64'(1));
        check("coinc_err", 64'(chk_err), 64'(1));
        chk_valid = 1'b0;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr2_cnt", 64'(err_cnt), 64'(0));
        chk_valid = 1'b1; chk_data = 4'b0110; chk_parity = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("sat_cnt", 64'(err_cnt), 64'((k > 3) ? 3 : k));
        end
        chk_valid = 1'b0;
        @(negedge clk);
        check("sat_idle_err", 64'(chk_err), 64'(0));
        check("sat_idle_cnt", 64'(err_cnt), 64'(3));
        chk_valid = 1'b1;
`endif

        data_in = 4'b0111; valid_in = 1'b1;
        @(posedge clk);
        #2;
        check("pre_rst_data_out", 64'(data_out), 64'(4'b0111));
        check("pre_rst_valid_out", 64'(valid_out), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_out", 64'(data_out), 64'(0));
        check("mid_rst_parity_out", 64'(parity_out), 64'(0));
        check("mid_rst_valid_out", 64'(valid_out), 64'(0));
        check("mid_rst_parity", 64'(parity), 64'(1));
`ifdef EPG_CHECK_EN
        check("mid_rst_chk_err", 64'(chk_err), 64'(0));
        check("mid_rst_err_cnt", 64'(err_cnt), 64'(0));
        check("mid_rst_sticky", 64'(err_sticky), 64'(0));
`endif
        @(posedge clk);
        #1;
        check("in_rst_valid_out", 64'(valid_out), 64'(0));
        check("in_rst_data_out", 64'(data_out), 64'(0));
        data_in = 4'b0110;
        #1;
        check("in_rst_parity", 64'(parity), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        valid_in = 1'b0;
`ifdef EPG_CHECK_EN
        chk_valid = 1'b0;
`endif
        @(negedge clk);
        check("post_rst_valid_out", 64'(valid_out), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
